// File: rtl/reorder_buffer_pkg.sv
// Shared core types for the reorder buffer: depth constants and the entry layout.
package core_types;
   localparam int ROB_DEPTH      = 8;
   localparam int ROB_DEPTH_BITS = $clog2(ROB_DEPTH);

   typedef struct packed {
      logic        valid;
      logic        done;
      logic        uses_rw;
      logic [4:0]  rw_addr;
      logic [5:0]  phy;
      logic [31:0] data;
   } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// In-order completion tracker: allocate at tail, complete by tag, retire from head.
// Optional macro ROB_WB_BYPASS_EN lets a writeback to the head retire in the same cycle.
module reorder_buffer #(
   parameter int ROB_DEPTH      = core_types::ROB_DEPTH,
   parameter int ROB_DEPTH_BITS = $clog2(ROB_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      alloc_valid,
   input  logic                      alloc_uses_rw,
   input  logic [4:0]                alloc_rw_addr,
   input  logic [5:0]                alloc_phy,
   output logic [ROB_DEPTH_BITS-1:0] rob_tag,
   output logic                      rob_full,
   output logic                      rob_empty,
   input  logic                      wb_valid,
   input  logic [ROB_DEPTH_BITS-1:0] wb_tag,
   input  logic [31:0]               wb_data,
   input  logic                      flush,
   output logic                      commit_wr_en,
   output logic [5:0]                commit_wr_addr,
   output logic [31:0]               commit_wr_data
);
   import core_types::*;

   rob_entry_t                ent_q [ROB_DEPTH];
   rob_entry_t                ent_d [ROB_DEPTH];
   rob_entry_t                head_ent;
   logic [ROB_DEPTH_BITS-1:0] head_q, head_d, tail_q, tail_d;
   logic [ROB_DEPTH_BITS:0]   count_q, count_d;
   logic                      commit_wr_en_q, commit_wr_en_d;
   logic [5:0]                commit_wr_addr_q, commit_wr_addr_d;
   logic [31:0]               commit_wr_data_q, commit_wr_data_d;
   logic                      alloc_ok, retire, bypass;

   assign rob_tag        = tail_q;
   assign rob_full       = (count_q == (ROB_DEPTH_BITS+1)'(ROB_DEPTH));
   assign rob_empty      = (count_q == '0);
   assign commit_wr_en   = commit_wr_en_q;
   assign commit_wr_addr = commit_wr_addr_q;
   assign commit_wr_data = commit_wr_data_q;

   always_comb begin
      ent_d            = ent_q;
      head_d           = head_q;
      tail_d           = tail_q;
      commit_wr_en_d   = 1'b0;
      commit_wr_addr_d = commit_wr_addr_q;
      commit_wr_data_d = commit_wr_data_q;
      head_ent         = ent_q[head_q];
      // Full is judged on registered occupancy, so a retire never frees a slot in its own cycle.
      alloc_ok         = alloc_valid & ~rob_full;
`ifdef ROB_WB_BYPASS_EN
      bypass           = wb_valid & (wb_tag == head_q) & head_ent.valid;
`else
      bypass           = 1'b0;
`endif
      retire           = head_ent.valid & (head_ent.done | bypass);

      if (wb_valid && ent_q[wb_tag].valid) begin
         ent_d[wb_tag].done = 1'b1;
         ent_d[wb_tag].data = wb_data;
      end

      if (retire) begin
         ent_d[head_q].valid = 1'b0;
         head_d              = head_q + ROB_DEPTH_BITS'(1);
         commit_wr_en_d      = head_ent.uses_rw & (head_ent.rw_addr != 5'd0);
         commit_wr_addr_d    = head_ent.phy;
         commit_wr_data_d    = bypass ? wb_data : head_ent.data;
      end

      if (alloc_ok) begin
         ent_d[tail_q].valid   = 1'b1;
         ent_d[tail_q].done    = 1'b0;
         ent_d[tail_q].uses_rw = alloc_uses_rw;
         ent_d[tail_q].rw_addr = alloc_rw_addr;
         ent_d[tail_q].phy     = alloc_phy;
         ent_d[tail_q].data    = '0;
         tail_d                = tail_q + ROB_DEPTH_BITS'(1);
      end

      count_d = count_q + {{ROB_DEPTH_BITS{1'b0}}, alloc_ok} - {{ROB_DEPTH_BITS{1'b0}}, retire};

      if (flush) begin
         for (int i = 0; i < ROB_DEPTH; i++) ent_d[i].valid = 1'b0;
         head_d         = '0;
         tail_d         = '0;
         count_d        = '0;
         commit_wr_en_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= '0;
         head_q           <= '0;
         tail_q           <= '0;
         count_q          <= '0;
         commit_wr_en_q   <= 1'b0;
         commit_wr_addr_q <= '0;
         commit_wr_data_q <= '0;
      end else begin
         for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= ent_d[i];
         head_q           <= head_d;
         tail_q           <= tail_d;
         count_q          <= count_d;
         commit_wr_en_q   <= commit_wr_en_d;
         commit_wr_addr_q <= commit_wr_addr_d;
         commit_wr_data_q <= commit_wr_data_d;
      end
   end
endmodule
